// File: rtl/shared_bus_arbiter.sv
// Shares one registered data/tag output bus between NUM_REQ valid/ready producers.
// Sticky round-robin priority: a requester may keep the bus for MAX_HOLD beats while others wait.
module shared_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 22,
  parameter int TAG_W    = 2,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [TAG_W-1:0]          out_tag,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // valid must not wait on ready, and a producer holds valid/data/tag until accepted.

  localparam int HC_W = $clog2(MAX_HOLD + 1);

  logic [ID_W-1:0] last_id;
  logic [HC_W-1:0] hold_cnt;
  logic            can_accept;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] start_id;
  logic [ID_W-1:0] win_id;
  logic [ID_W:0]   idx;
  logic [HC_W-1:0] hold_next;

  assign can_accept = !out_valid || out_ready;
  assign busy       = out_valid || (|req_valid);

  always_comb begin
    start_id = last_id;
    if (hold_cnt >= HC_W'(MAX_HOLD)) begin
      start_id = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
    end
    found  = 1'b0;
    win_id = start_id;
    idx    = '0;
    // Scan from the farthest offset down so the nearest valid requester is the final winner.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, start_id} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NUM_REQ)) begin
        idx = idx - (ID_W + 1)'(NUM_REQ);
      end
      if (req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = idx[ID_W-1:0];
      end
    end
    grant     = found && can_accept && rst;
    req_ready = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
    hold_next = 1;
    if (win_id == last_id) begin
      hold_next = (hold_cnt >= HC_W'(MAX_HOLD)) ? HC_W'(MAX_HOLD) : hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      grant_id  <= '0;
      last_id   <= '0;
      hold_cnt  <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= req_data[win_id*DATA_W +: DATA_W];
      out_tag   <= req_tag[win_id*TAG_W +: TAG_W];
      grant_id  <= win_id;
      last_id   <= win_id;
      hold_cnt  <= hold_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Shares one registered 22-bit data / 2-bit tag output bus between NUM_REQ requesters using valid/ready handshakes.
- Priority is sticky round-robin with a bounded hold: a requester keeps the bus for up to MAX_HOLD consecutive beats while others wait.
- Sits between several producer interfaces and a single downstream consumer port, such as the wide outOther-style bus and the 2-bit sideband of the top-level module.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 22: payload width.
- TAG_W, 2: sideband tag width.
- MAX_HOLD, 4: maximum consecutive grants to one requester while another requester is valid (>=1; 1 gives pure round-robin).
- ID_W, $clog2(NUM_REQ): width of the grant index.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_tag  in  NUM_REQ*TAG_W  tags; requester i occupies bits [i*TAG_W +: TAG_W].
- req_ready  out  NUM_REQ  per-requester accept, combinational; one-hot or zero.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DATA_W  output payload (registered).
- out_tag  out  TAG_W  output tag (registered).
- out_ready  in  1  downstream accept.
- grant_id  out  ID_W  index of the requester whose beat is in the output register.
- busy  out  1  out_valid | (|req_valid).

Behaviour:
- Reset (rst=0 at a rising edge):
  - out_valid, out_data, out_tag, grant_id all go to 0.
  - Internal last_id=0 and hold_cnt=0.
  - Any beat in the output register is dropped.
  - req_ready is 0 while rst=0.
- Slot free: can_accept = !out_valid | out_ready.
- Winner search, when can_accept=1 and any req_valid=1:
  - Search start index is last_id if hold_cnt<MAX_HOLD; otherwise (last_id+1) mod NUM_REQ.
  - Winner is the first valid requester scanning upward from the start index, wrapping at NUM_REQ.
  - If hold_cnt==MAX_HOLD and last_id is the only valid requester, last_id wins again.
- Grant:
  - req_ready[winner]=1 in the same cycle; all other req_ready bits are 0.
  - req_ready never depends combinationally on req_data or req_tag.
- Handshake on req_valid[w] & req_ready[w]:
  - At the next edge, out_data/out_tag take requester w's slices, out_valid=1, grant_id=w.
  - Latency is 1 cycle from accept to out_valid.
- hold_cnt update on each grant:
  - If w==last_id: hold_cnt = min(hold_cnt+1, MAX_HOLD).
  - Otherwise: hold_cnt=1.
  - Then last_id=w.
- Drain without refill: out_valid & out_ready with no winner clears out_valid next edge. out_data, out_tag and grant_id hold their values.
- Simultaneous drain and refill: the new beat is loaded with no bubble, sustaining 1 beat/cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - all req_ready bits are 0;
  - out_* and grant_id are stable;
  - last_id and hold_cnt are frozen.
- No requests: last_id and hold_cnt are retained, so priority is sticky across idle gaps.
- Requester rule: a requester must hold valid/data/tag stable until accepted. The arbiter does not check this.

Test Plan:
1. Hold rst=0 for 2 cycles with req_valid=4'b1111 and out_ready=1 -> req_ready=0, out_valid=0, out_data=0, out_tag=0, grant_id=0, busy=1.
2. After reset, requester 2 only, data 22'h15A5A5, tag 2'b10, out_ready=1 -> req_ready=4'b0100 in cycle N. In cycle N+1: out_valid=1, out_data=22'h15A5A5, out_tag=2'b10, grant_id=2. In cycle N+2: out_valid=0.
3. All four requesters continuously valid, out_ready=1, MAX_HOLD=4 -> grant_id over consecutive beats is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; one beat per cycle, no bubbles.
4. Beat from requester 1 in output register, out_ready=0 for 3 cycles with requester 3 valid -> req_ready=0 and out_* unchanged for those cycles. Cycle out_ready returns to 1: req_ready=4'b1000; next cycle grant_id=3.
5. MAX_HOLD=1, requesters 1 and 3 continuously valid -> grant_id alternates 1,3,1,3. Then requester 1 drops: grant_id stays 3 every cycle.
6. rst=0 for one edge while out_valid=1 (grant_id=2, hold_cnt=3) -> next cycle out_valid=0, grant_id=0. With all requesters then valid, the first grant goes to requester 0.
